// File: rtl/decode_execute_register.sv
// -----------------------------------------------------------------------------
// decode_execute_register
//
// Pipeline register between the decode and execute stages. It captures the
// decode control word, the operands and the destination index, and presents
// them to execute one cycle later. It also:
//   - detects a load in execute whose destination feeds the instruction in
//     decode (load-use), and loads a bubble while decode holds;
//   - honours execute stall (hold) and flush (squash to bubble) requests;
//   - keeps a saturating count of load-use bubbles for performance debug.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   validD                     decode slot holds a real instruction
//   writeEnableDD, writeDataEnableMD, resultSelectorWBD,
//   data2SelectorED, outFlag   decode control bits
//   aluControlED [2:0]         decode ALU control
//   rd1D, rd2D, immD           register-file reads and immediate
//   rs1D, rs2D, rdD            source and destination register indices
//   stallE                     execute cannot accept; hold contents
//   flushE                     squash the execute slot
//   writeEnableE .. outFlagE   registered control bits
//   aluControlE [2:0]          registered ALU control
//   rd1E, rd2E, immE, rdE      registered operands and destination
//   validE                     execute slot holds a real instruction
//   stallD                     combinational hold request to fetch/decode
//   hazardCount                saturating load-use bubble count
// -----------------------------------------------------------------------------
module decode_execute_register #(
   parameter int DATAWIDTH    = 32,
   parameter int REGADDRWIDTH = 4,
   parameter int CNTWIDTH     = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    validD,
   input  logic                    writeEnableDD,
   input  logic                    writeDataEnableMD,
   input  logic                    resultSelectorWBD,
   input  logic                    data2SelectorED,
   input  logic                    outFlag,
   input  logic [2:0]              aluControlED,
   input  logic [DATAWIDTH-1:0]    rd1D,
   input  logic [DATAWIDTH-1:0]    rd2D,
   input  logic [DATAWIDTH-1:0]    immD,
   input  logic [REGADDRWIDTH-1:0] rs1D,
   input  logic [REGADDRWIDTH-1:0] rs2D,
   input  logic [REGADDRWIDTH-1:0] rdD,
   input  logic                    stallE,
   input  logic                    flushE,
   output logic                    writeEnableE,
   output logic                    writeDataEnableE,
   output logic                    resultSelectorE,
   output logic                    data2SelectorE,
   output logic                    outFlagE,
   output logic [2:0]              aluControlE,
   output logic [DATAWIDTH-1:0]    rd1E,
   output logic [DATAWIDTH-1:0]    rd2E,
   output logic [DATAWIDTH-1:0]    immE,
   output logic [REGADDRWIDTH-1:0] rdE,
   output logic                    validE,
   output logic                    stallD,
   output logic [CNTWIDTH-1:0]     hazardCount
);

   // One execute-slot entry. A bubble is the all-zero entry.
   typedef struct packed {
      logic                    write_enable;
      logic                    write_data_enable;
      logic                    result_selector;
      logic                    data2_selector;
      logic                    out_flag;
      logic [2:0]              alu_control;
      logic [DATAWIDTH-1:0]    rd1;
      logic [DATAWIDTH-1:0]    rd2;
      logic [DATAWIDTH-1:0]    imm;
      logic [REGADDRWIDTH-1:0] rd;
      logic                    valid;
   } entry_t;

   localparam entry_t BUBBLE = '0;
   localparam logic [CNTWIDTH-1:0] COUNT_MAX = '1;

   entry_t              entry_reg;
   entry_t              entry_next;
   entry_t              captured;
   logic [CNTWIDTH-1:0] count_reg;
   logic [CNTWIDTH-1:0] count_next;
   logic                src1_match;
   logic                src2_match;
   logic                load_use;

   // ---------------------------------------------------------------------
   // Load-use detection. Operand 2 is only a source when it is not the
   // immediate. Register 0 is compared like any other index.
   // ---------------------------------------------------------------------
   always_comb begin
      src1_match = (entry_reg.rd == rs1D);
      src2_match = ~data2SelectorED & (entry_reg.rd == rs2D);
      load_use   = entry_reg.valid & entry_reg.write_enable &
                   entry_reg.result_selector & validD &
                   (src1_match | src2_match);
   end

   // Decode must hold either for a load-use bubble or because execute is
   // stalled. A flush does not by itself stall decode.
   assign stallD = load_use | stallE;

   // ---------------------------------------------------------------------
   // Entry presented by decode; an invalid decode slot becomes a bubble so
   // no stray control bits reach execute.
   // ---------------------------------------------------------------------
   always_comb begin
      captured                   = BUBBLE;
      if (validD) begin
         captured.write_enable      = writeEnableDD;
         captured.write_data_enable = writeDataEnableMD;
         captured.result_selector   = resultSelectorWBD;
         captured.data2_selector    = data2SelectorED;
         captured.out_flag          = outFlag;
         captured.alu_control       = aluControlED;
         captured.rd1               = rd1D;
         captured.rd2               = rd2D;
         captured.imm               = immD;
         captured.rd                = rdD;
         captured.valid             = 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state selection: flush > stall > load-use bubble > capture.
   // Only the load-use bubble advances the hazard counter.
   // ---------------------------------------------------------------------
   always_comb begin
      entry_next = entry_reg;
      count_next = count_reg;
      if (flushE) begin
         entry_next = BUBBLE;
      end else if (stallE) begin
         entry_next = entry_reg;
      end else if (load_use) begin
         entry_next = BUBBLE;
         if (count_reg != COUNT_MAX) begin
            count_next = count_reg + CNTWIDTH'(1);
         end
      end else begin
         entry_next = captured;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry_reg <= BUBBLE;
         count_reg <= '0;
      end else begin
         entry_reg <= entry_next;
         count_reg <= count_next;
      end
   end

   assign writeEnableE     = entry_reg.write_enable;
   assign writeDataEnableE = entry_reg.write_data_enable;
   assign resultSelectorE  = entry_reg.result_selector;
   assign data2SelectorE   = entry_reg.data2_selector;
   assign outFlagE         = entry_reg.out_flag;
   assign aluControlE      = entry_reg.alu_control;
   assign rd1E             = entry_reg.rd1;
   assign rd2E             = entry_reg.rd2;
   assign immE             = entry_reg.imm;
   assign rdE              = entry_reg.rd;
   assign validE           = entry_reg.valid;
   assign hazardCount      = count_reg;

endmodule
